// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: FSM states and
// default geometry.
package icache_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_LINES  = 8;
    localparam int DEF_WORDS  = 4;
    localparam int DEF_CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        DONE   = 2'd2
    } state_e;

    // Width of a field that must exist even when it would carry no information.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/icache_line_array.sv
// Tag/valid/data storage for the cache: one asynchronous read port, one
// word-write port, tag write with valid set, and per-line / global invalidate.
module icache_line_array
    import icache_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LINES  = DEF_LINES,
    parameter int WORDS  = DEF_WORDS,
    parameter int TAG_W  = 25,
    parameter int IDX_W  = 3,
    parameter int OFF_W  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IDX_W-1:0]  rd_idx,
    input  logic [OFF_W-1:0]  rd_off,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [OFF_W-1:0]  wr_off,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              tag_we,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic              inv_line,
    input  logic [IDX_W-1:0]  inv_idx,
    input  logic              inv_all
);

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [DATA_W-1:0] data_q [LINES][WORDS];

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx][rd_off];

    // Invalidation wins over a tag write; the FSM never issues both to one line.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else begin
            for (int l = 0; l < LINES; l++) begin
                if (inv_all || (inv_line && inv_idx == IDX_W'(l)))
                    valid_q[l] <= 1'b0;
                else if (tag_we && wr_idx == IDX_W'(l))
                    valid_q[l] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (tag_we)
            tag_q[wr_idx] <= wr_tag;
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            data_q[wr_idx][wr_off] <= wr_data;
    end

endmodule

// File: rtl/pipe_icache.sv
// Blocking direct-mapped instruction cache: single-cycle hits, word-by-word
// line refill on a miss, deferred flush during refill, saturating hit/miss counters.
module pipe_icache
    import icache_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int LINES  = DEF_LINES,
    parameter int WORDS  = DEF_WORDS,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    input  logic              flush,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    localparam int OFF    = $clog2(WORDS);
    localparam int OFF_W  = clog2_min1(WORDS);
    localparam int IDX_W  = $clog2(LINES);
    localparam int TAG_W  = ADDR_W - 2 - OFF - IDX_W;
    localparam int LINE_W = TAG_W + IDX_W;

    state_e state_q, state_d;

    logic [ADDR_W-3:0] cpu_word;
    logic [OFF_W-1:0]  cpu_off;
    logic [IDX_W-1:0]  cpu_idx;
    logic [TAG_W-1:0]  cpu_tag;
    logic              unused_addr_lsbs;

    logic [LINE_W-1:0] lat_line_q;
    logic [OFF_W-1:0]  wcnt_q;
    logic              pend_q;
    logic [CNT_W-1:0]  hit_q, miss_q;

    logic              rd_valid;
    logic [TAG_W-1:0]  rd_tag;
    logic              hit;
    logic              last_word;
    logic              hit_ev, miss_ev, latch, wr_en, tag_we, inv_line, inv_all;

    assign cpu_word         = cpu_addr[ADDR_W-1:2];
    assign unused_addr_lsbs = ^cpu_addr[1:0];
    assign cpu_idx          = cpu_word[OFF +: IDX_W];
    assign cpu_tag          = cpu_word[OFF+IDX_W +: TAG_W];

    if (WORDS > 1) begin : g_off
        assign cpu_off  = cpu_word[OFF_W-1:0];
        assign mem_addr = {lat_line_q, wcnt_q, 2'b00};
    end else begin : g_no_off
        assign cpu_off  = '0;
        assign mem_addr = {lat_line_q, 2'b00};
    end

    icache_line_array #(
        .DATA_W (DATA_W),
        .LINES  (LINES),
        .WORDS  (WORDS),
        .TAG_W  (TAG_W),
        .IDX_W  (IDX_W),
        .OFF_W  (OFF_W)
    ) u_array (
        .clk      (clk),
        .reset    (reset),
        .rd_idx   (cpu_idx),
        .rd_off   (cpu_off),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (cpu_rdata),
        .wr_en    (wr_en),
        .wr_idx   (lat_line_q[IDX_W-1:0]),
        .wr_off   (wcnt_q),
        .wr_data  (mem_rdata),
        .tag_we   (tag_we),
        .wr_tag   (lat_line_q[IDX_W +: TAG_W]),
        .inv_line (inv_line),
        .inv_idx  (cpu_idx),
        .inv_all  (inv_all)
    );

    assign hit       = rd_valid && (rd_tag == cpu_tag);
    assign last_word = (wcnt_q == OFF_W'(WORDS - 1));

    always_comb begin
        state_d   = state_q;
        cpu_ready = 1'b0;
        mem_req   = 1'b0;
        hit_ev    = 1'b0;
        miss_ev   = 1'b0;
        latch     = 1'b0;
        wr_en     = 1'b0;
        tag_we    = 1'b0;
        inv_line  = 1'b0;
        inv_all   = 1'b0;
        case (state_q)
            IDLE: begin
                inv_all = flush;
                if (cpu_req) begin
                    if (hit) begin
                        cpu_ready = 1'b1;
                        hit_ev    = 1'b1;
                    end else begin
                        miss_ev  = 1'b1;
                        latch    = 1'b1;
                        inv_line = 1'b1;
                        state_d  = REFILL;
                    end
                end
            end
            REFILL: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    wr_en = 1'b1;
                    if (last_word) begin
                        tag_we  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                // A flush seen during the refill also drops the line just filled.
                inv_all = pend_q || flush;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            lat_line_q <= '0;
            wcnt_q     <= '0;
            pend_q     <= 1'b0;
            hit_q      <= '0;
            miss_q     <= '0;
        end else begin
            state_q <= state_d;
            if (latch)
                lat_line_q <= cpu_word[ADDR_W-3:OFF];
            if (state_q == REFILL && mem_ack)
                wcnt_q <= last_word ? '0 : wcnt_q + 1'b1;
            if (state_q == DONE)
                pend_q <= 1'b0;
            else if (state_q == REFILL && flush)
                pend_q <= 1'b1;
            if (hit_ev && hit_q != {CNT_W{1'b1}})
                hit_q <= hit_q + 1'b1;
            if (miss_ev && miss_q != {CNT_W{1'b1}})
                miss_q <= miss_q + 1'b1;
        end
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;

endmodule
